// File: rtl/counter_search_engine.sv
`default_nettype none
// ============================================================================
// Module      : counter_search_engine
// Description : Brute-force search engine. A counter generates candidate
//               values 0..MAX_COUNT and injects them into a PIPE_DEPTH-stage
//               pipeline. The value leaving the last stage is compared with a
//               target latched at start. The search pauses and resumes under
//               control of 'enable' without skipping or duplicating
//               candidates, and ends in FOUND (match) or DONE (exhausted).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK            in   1   sole clock, rising edge
//   CPU_RESETN     in   1   asynchronous assert, active-low reset
//   enable         in   1   1 = run, 0 = pause
//   target         in   32  value searched for, sampled at start only
//   candidate      out  32  counter value (next value to inject)
//   found_value    out  32  matched value while status_found=1, else 0
//   status_paused  out  1   one-hot state flags
//   status_warming out  1
//   status_running out  1
//   status_found   out  1
//   status_done    out  1
// ============================================================================
module counter_search_engine #(
  parameter int unsigned PIPE_DEPTH = 8,
  parameter logic [31:0] MAX_COUNT  = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        CPU_RESETN,
  input  logic        enable,
  input  logic [31:0] target,
  output logic [31:0] candidate,
  output logic [31:0] found_value,
  output logic        status_paused,
  output logic        status_warming,
  output logic        status_running,
  output logic        status_found,
  output logic        status_done
);

  localparam logic [2:0] ST_PAUSED  = 3'd0;
  localparam logic [2:0] ST_WARMING = 3'd1;
  localparam logic [2:0] ST_RUNNING = 3'd2;
  localparam logic [2:0] ST_FOUND   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // --------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, release is aligned to CLK so
  // no register sees reset removal close to an active edge.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]                   state_q,     state_d;
  logic [2:0]                   resume_q,    resume_d;
  logic                         started_q,   started_d;
  logic [31:0]                  target_q,    target_d;
  logic [31:0]                  counter_q,   counter_d;
  logic                         max_inj_q,   max_inj_d;   // MAX_COUNT already injected
  logic [31:0]                  found_q,     found_d;
  logic [PIPE_DEPTH-1:0][31:0]  stage_val_q, stage_val_d;
  logic [PIPE_DEPTH-1:0]        stage_vld_q, stage_vld_d;

  logic [31:0] tail_val;
  logic        tail_vld;

  assign tail_val = stage_val_q[PIPE_DEPTH-1];
  assign tail_vld = stage_vld_q[PIPE_DEPTH-1];

  always_comb begin
    state_d     = state_q;
    resume_d    = resume_q;
    started_d   = started_q;
    target_d    = target_q;
    counter_d   = counter_q;
    max_inj_d   = max_inj_q;
    found_d     = found_q;
    stage_val_d = stage_val_q;
    stage_vld_d = stage_vld_q;

    case (state_q)
      ST_PAUSED: begin
        if (enable) begin
          if (!started_q) begin
            // Start edge: latch the target only; first injection is next edge.
            started_d = 1'b1;
            target_d  = target;
            state_d   = ST_WARMING;
          end else begin
            // Resume edge: no injection, advancing restarts on the next edge.
            state_d = resume_q;
          end
        end
      end

      ST_WARMING, ST_RUNNING: begin
        if (!enable) begin
          state_d  = ST_PAUSED;
          resume_d = state_q;
        end else begin
          // Advancing edge: inject, shift, count and compare the tail.
          stage_val_d = {stage_val_q[PIPE_DEPTH-2:0], counter_q};
          stage_vld_d = {stage_vld_q[PIPE_DEPTH-2:0], ~max_inj_q};
          if (!max_inj_q) begin
            if (counter_q == MAX_COUNT) begin
              max_inj_d = 1'b1;       // counter parks at MAX_COUNT
            end else begin
              counter_d = counter_q + 32'd1;
            end
          end

          if (tail_vld && (tail_val == target_q)) begin
            state_d = ST_FOUND;
            found_d = tail_val;
          end else if (tail_vld && (tail_val == MAX_COUNT)) begin
            state_d = ST_DONE;
          end else if ((state_q == ST_WARMING) && stage_vld_q[PIPE_DEPTH-2]) begin
            // The first valid value is moving into the last stage this edge.
            state_d = ST_RUNNING;
          end
        end
      end

      ST_FOUND, ST_DONE: begin
        // Terminal until reset.
      end

      default: begin
        state_d = ST_PAUSED;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PAUSED;
      resume_q    <= ST_WARMING;
      started_q   <= 1'b0;
      target_q    <= 32'd0;
      counter_q   <= 32'd0;
      max_inj_q   <= 1'b0;
      found_q     <= 32'd0;
      stage_val_q <= '0;
      stage_vld_q <= '0;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      started_q   <= started_d;
      target_q    <= target_d;
      counter_q   <= counter_d;
      max_inj_q   <= max_inj_d;
      found_q     <= found_d;
      stage_val_q <= stage_val_d;
      stage_vld_q <= stage_vld_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign candidate      = counter_q;
  assign found_value    = found_q;   // only ever loaded on entry to FOUND
  assign status_paused  = (state_q == ST_PAUSED);
  assign status_warming = (state_q == ST_WARMING);
  assign status_running = (state_q == ST_RUNNING);
  assign status_found   = (state_q == ST_FOUND);
  assign status_done    = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: doc/counter_search_engine.md
COUNTER_SEARCH_ENGINE -- requirements
Module: counter_search_engine

Interface
REQ-001 Parameter PIPE_DEPTH, default 8: candidate pipeline stages (>=2) between counter and comparator.
REQ-002 Parameter MAX_COUNT, default 32'hFFFF_FFFF: last candidate value generated.
REQ-003 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 CPU_RESETN  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  1  level from driver; 1 = run, 0 = pause.
REQ-006 target  input  32  value searched for; sampled only at start.
REQ-007 candidate  output  32  current counter value (next value to inject).
REQ-008 found_value  output  32  matched value; valid while status_found=1.
REQ-009 status_paused, status_warming, status_running, status_found, status_done  output  1 each  state flags, exactly one high at all times.

Function
REQ-010 States: PAUSED, WARMING, RUNNING, FOUND, DONE; each drives only its own status flag.
REQ-011 Registered resume state (WARMING or RUNNING) and started bit; PAUSED returns to resume state.
REQ-012 Edge E0 = first edge sampling enable=1 in PAUSED with started=0: latch target, started<=1, go WARMING; no injection at E0.
REQ-013 Advancing edge = edge in WARMING/RUNNING with enable=1: stage0<=counter with valid=1 (valid=0 once MAX_COUNT injected), stages shift one place, counter<=counter+1.
REQ-014 Counter holds at MAX_COUNT after injecting it; never wraps to 0.
REQ-015 Value v injected at E(v+1) occupies stage PIPE_DEPTH-1 after E(v+PIPE_DEPTH).
REQ-016 WARMING->RUNNING on the edge at which the first valid value enters stage PIPE_DEPTH-1, i.e. E(PIPE_DEPTH).
REQ-017 Comparator: on advancing edge, if stage PIPE_DEPTH-1 valid and equals latched target -> FOUND, found_value<=that value; match on v sets FOUND at E(v+PIPE_DEPTH+1).
REQ-018 DONE when stage PIPE_DEPTH-1 holds valid MAX_COUNT, it does not match, and edge is advancing.
REQ-019 Match on MAX_COUNT itself: FOUND, never DONE.
REQ-020 Edge sampling enable=0 in WARMING/RUNNING: PAUSED, resume state saved; pipeline, counter, valids frozen; no comparison while PAUSED.
REQ-021 Edge sampling enable=1 in PAUSED with started=1: return to resume state, no injection that edge; advancing resumes next edge; no candidate skipped or duplicated.
REQ-022 FOUND and DONE terminal until reset; enable and target ignored; counter and pipeline frozen.
REQ-023 target changes after E0 have no effect.
REQ-024 found_value holds 0 in every state except FOUND.

Reset
REQ-025 CPU_RESETN=0 immediately, regardless of clock: state PAUSED (status_paused=1, others 0), started=0, counter=0, candidate=0, found_value=0, all stage valids 0, latched target 0.
REQ-026 Reset mid-search discards all progress; next start re-latches target and begins at 0.
REQ-027 Reset release is synchronised to CLK so the first active edge is glitch-free.

Verification
REQ-028 PIPE_DEPTH=8, target=0x10, enable held 1 from E0 -> status_warming E0..E7, status_running from E8, status_found from E25, found_value=0x10, candidate frozen at 0x19.
REQ-029 target=0x0, PIPE_DEPTH=8 -> status_found after E9, found_value=0x0; no other flag high afterward.
REQ-030 MAX_COUNT=0x20, target=0x40 -> status_done after E41, status_found never 1, candidate=0x20.
REQ-031 MAX_COUNT=0x20, target=0x20 -> status_found after E41, status_done never 1.
REQ-032 target=0x10, enable dropped 3 cycles at E5 and again at E20 -> status_paused during gaps, found_value=0x10, FOUND delayed exactly by pause cycles; target changed mid-run to 0x5 ignored.
REQ-033 CPU_RESETN pulsed low mid-RUNNING, no clock edge -> all outputs at reset values at once; restart finds target from 0 with REQ-028 timing.
